// File: rtl/apb_master_if.sv
// APB bus bundle between apb_master and a completer; the master drives
// select/enable/address/write data, the completer returns ready/read data/error.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command in, one APB transfer out,
// one response back, with an optional ACCESS-phase wait timeout.
//
// state  | meaning
// IDLE   | no transfer; accepts a command when no response is pending
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    apb_master_if.master          apb
);

    // A disabled timeout still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  timeout_hit;

    // Gated by PRESETn so nothing looks acceptable while the block is held in reset.
    assign cmd_ready   = (state_q == IDLE) && !rsp_valid_q && PRESETn;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a completion on the last allowed cycle wins.
                if (apb.PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = apb.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : apb.PRDATA;
                    state_d       = IDLE;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = IDLE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table plus randomized transfers checked
// against a transaction-level model of the expected response and ACCESS length.
module tb_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .apb         (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        int            waits;      // ACCESS cycles with PREADY low before it rises
        bit            slverr;
        int            rsp_delay;  // cycles rsp_ready stays low
        logic [DW-1:0] exp_rdata;
        bit            exp_slverr;
        bit            exp_timeout;
        int            exp_cycles; // ACCESS cycles observed
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: a transfer either completes on the cycle
    // PREADY rises or is aborted after TO ACCESS cycles, whichever comes first.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits >= TO) begin
            r.exp_cycles  = TO;
            r.exp_rdata   = '0;
            r.exp_slverr  = 1'b1;
            r.exp_timeout = 1'b1;
        end else begin
            r.exp_cycles  = v.waits + 1;
            r.exp_rdata   = v.write ? '0 : v.prdata;
            r.exp_slverr  = v.slverr;
            r.exp_timeout = 1'b0;
        end
        return r;
    endfunction

    task automatic junk_slave();
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        int k;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        chk("setup_psel", {63'd0, bus.PSEL}, 64'd1);
        chk("setup_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("setup_paddr", {32'd0, bus.PADDR}, {32'd0, v.addr});
        chk("setup_pwrite", {63'd0, bus.PWRITE}, {63'd0, v.write});
        chk("setup_pwdata", {32'd0, bus.PWDATA}, {32'd0, v.wdata});
        junk_slave();
        @(posedge PCLK); #1;
        k = 0;
        do begin
            k++;
            chk("access_psel", {63'd0, bus.PSEL}, 64'd1);
            chk("access_penable", {63'd0, bus.PENABLE}, 64'd1);
            chk("access_paddr", {32'd0, bus.PADDR}, {32'd0, v.addr});
            chk("access_pwdata", {32'd0, bus.PWDATA}, {32'd0, v.wdata});
            if (k > v.waits) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = v.slverr;
                bus.PRDATA  = v.prdata;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'($urandom);
                bus.PRDATA  = $urandom;
            end
            @(posedge PCLK); #1;
        end while (!rsp_valid && k < 40);
        junk_slave();
        chk("access_cycles", 64'(k), 64'(v.exp_cycles));
        chk("done_psel", {63'd0, bus.PSEL}, 64'd0);
        chk("done_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("done_paddr_kept", {32'd0, bus.PADDR}, {32'd0, v.addr});
        // Offer another command while the response waits; it must be refused.
        cmd_valid = 1'b1;
        for (int d = 0; d <= v.rsp_delay; d++) begin
            chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
            chk("rsp_slverr", {63'd0, rsp_slverr}, {63'd0, v.exp_slverr});
            chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, v.exp_timeout});
            chk("rsp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            chk("rsp_psel", {63'd0, bus.PSEL}, 64'd0);
            rsp_ready = (d == v.rsp_delay);
            @(posedge PCLK); #1;
            junk_slave();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("hs_no_setup", {63'd0, bus.PSEL}, 64'd0);
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hFFFF_FFFF;

        //        wr addr           wdata          prdata         wt sl dl  exp_rdata      es et cyc
        vecs[0] = '{1, 32'h10, 32'hA5A5_A5A5, 32'h0,         0, 0, 0, 32'h0,         0, 0, 1};
        vecs[1] = '{0, 32'h20, 32'h0,         32'h1234_5678, 3, 0, 0, 32'h1234_5678, 0, 0, 4};
        vecs[2] = '{1, 32'h30, 32'hDEAD_BEEF, 32'h9999_9999, 0, 1, 1, 32'h0,         1, 0, 1};
        vecs[3] = '{0, 32'h40, 32'h0,         32'h7777_7777, 20,0, 0, 32'h0,         1, 1, 16};
        vecs[4] = '{0, 32'h44, 32'h0,         32'hCAFE_F00D, 15,0, 5, 32'hCAFE_F00D, 0, 0, 16};
        vecs[5] = '{1, 32'h48, 32'h1111_2222, 32'h0,         16,0, 2, 32'h0,         1, 1, 16};
        vecs[6] = '{0, 32'h4C, 32'h0,         32'h0000_55AA, 2, 1, 0, 32'h0000_55AA, 1, 0, 3};

        #12;
        chk("rst_psel", {63'd0, bus.PSEL}, 64'd0);
        chk("rst_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("rst_paddr", {32'd0, bus.PADDR}, 64'd0);
        chk("rst_pwrite", {63'd0, bus.PWRITE}, 64'd0);
        chk("rst_pwdata", {32'd0, bus.PWDATA}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_rsp_slverr", {63'd0, rsp_slverr}, 64'd0);
        chk("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        cmd_valid = 1'b1;
        #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            rv.write     = 1'($urandom);
            rv.addr      = $urandom;
            rv.wdata     = $urandom;
            rv.prdata    = $urandom;
            rv.waits     = $urandom_range(0, 20);
            rv.slverr    = 1'($urandom);
            rv.rsp_delay = $urandom_range(0, 3);
            run_txn(model(rv));
        end

        // Reset in the middle of ACCESS: everything drops at once, no response follows.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h60;
        @(posedge PCLK); #1;
        cmd_valid   = 1'b0;
        bus.PREADY  = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel", {63'd0, bus.PSEL}, 64'd0);
        chk("midrst_penable", {63'd0, bus.PENABLE}, 64'd0);
        chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_paddr", {32'd0, bus.PADDR}, 64'd0);
        @(negedge PCLK);
        PRESETn    = 1'b1;
        bus.PREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK); #1;
            chk("postrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("postrst_psel", {63'd0, bus.PSEL}, 64'd0);
        end

        // Command pending across reset release is taken on the first edge after it.
        @(negedge PCLK);
        PRESETn   = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h70;
        cmd_wdata = 32'h0BAD_F00D;
        #1;
        chk("inrst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        chk("rel_setup_psel", {63'd0, bus.PSEL}, 64'd1);
        chk("rel_setup_paddr", {32'd0, bus.PADDR}, 64'h70);
        @(posedge PCLK); #1;
        chk("rel_access_penable", {63'd0, bus.PENABLE}, 64'd1);
        @(posedge PCLK); #1;
        chk("rel_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rel_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        chk("rel_hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 16, max ACCESS wait cycles (0 = timeout disabled).
REQ-004 SHALL have ports: PCLK in 1 clock; PRESETn in 1 async active-low reset.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1 write, 0 read); cmd_addr in ADDR_WIDTH; cmd_wdata in DATA_WIDTH.
REQ-007 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_WIDTH; rsp_slverr out 1; rsp_timeout out 1.
REQ-008 SHALL have APB ports: PSEL out 1; PENABLE out 1; PADDR out ADDR_WIDTH; PWRITE out 1; PWDATA out DATA_WIDTH; PREADY in 1; PRDATA in DATA_WIDTH; PSLVERR in 1.

Function
REQ-009 SHALL implement FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-010 SHALL drive cmd_ready = (state==IDLE) && !rsp_valid, combinationally from registered state.
REQ-011 SHALL, on edge with cmd_valid&&cmd_ready, latch cmd_addr/cmd_write/cmd_wdata onto PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, go SETUP.
REQ-012 SHALL go SETUP->ACCESS unconditionally on next edge, setting PENABLE=1, PSEL held 1.
REQ-013 SHALL hold PADDR, PWRITE, PWDATA stable from SETUP through end of ACCESS; retain last values while IDLE.
REQ-014 SHALL, in ACCESS on edge with PREADY=1, set PSEL=0, PENABLE=0, rsp_valid=1, rsp_slverr=PSLVERR, rsp_timeout=0, rsp_rdata=PRDATA for reads or 0 for writes, go IDLE.
REQ-015 SHALL remain in ACCESS with PSEL=1, PENABLE=1 while PREADY=0 and timeout not reached.
REQ-016 SHALL count wait cycles: counter cleared on SETUP->ACCESS, incremented each ACCESS edge with PREADY=0.
REQ-017 SHALL, when TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 at an ACCESS edge with PREADY=0, abort: PSEL=0, PENABLE=0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, go IDLE.
REQ-018 SHALL give PREADY=1 priority over timeout on the same edge (normal completion).
REQ-019 SHALL hold rsp_valid and response fields stable until edge with rsp_valid&&rsp_ready, then clear rsp_valid.
REQ-020 SHALL not accept a new command while rsp_valid=1; first new SETUP earliest one cycle after the response handshake edge.
REQ-021 SHALL achieve minimum latency: accept edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid asserted after edge N+2 if PREADY=1 (zero-wait).
REQ-022 SHALL size the wait counter as clog2(TIMEOUT_CYCLES+1) bits, never wrap.
REQ-023 SHALL ignore PREADY, PSLVERR, PRDATA outside ACCESS.

Reset
REQ-024 SHALL, on PRESETn=0 asynchronously: state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, counter=0.
REQ-025 SHALL abandon any in-flight transfer or pending response on reset mid-operation, no response generated.
REQ-026 SHALL keep cmd_ready=0 while PRESETn=0; first accept on first edge after release.

Verification
REQ-027 Zero-wait write addr 0x10 data 0xA5A5_A5A5, PREADY=1 -> SETUP 1 cycle, ACCESS 1 cycle, PWDATA stable, rsp_valid=1, rsp_slverr=0, rsp_rdata=0.
REQ-028 Read addr 0x20, PREADY low 3 cycles then high with PRDATA=0x1234_5678 -> ACCESS 4 cycles, rsp_rdata=0x1234_5678.
REQ-029 Write with PSLVERR=1 at PREADY=1 -> rsp_slverr=1, rsp_timeout=0.
REQ-030 PREADY held 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, PSEL=0.
REQ-031 rsp_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready=0, no SETUP until after handshake; response fields unchanged.
REQ-032 PRESETn asserted during ACCESS -> PSEL/PENABLE/rsp_valid=0 immediately, no response after release.
